// File: rtl/msf_keyer.sv
`default_nettype none
// ============================================================================
// Module   : msf_keyer
// Purpose  : MSF-format time-code transmitter. It on/off keys a baseband
//            carrier envelope from per-minute A/B bit frames. It emits a
//            carrier-period strobe, a one-second marker, a minute marker and
//            an unsigned-magnitude amplitude stream for the IQ averager.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               in   1      system clock
//   rst               in   1      synchronous, active-high reset
//   enable            in   1      run keyer; low returns to IDLE next clk
//   frame_a           in   60     A bits, bit s sent in second s (bit 0 unused)
//   frame_b           in   60     B bits, bit s sent in second s (bit 0 unused)
//   frame_valid       in   1      frame_a/b valid
//   frame_ready       out  1      shadow register empty
//   amplitude_level   in   NBITS  envelope level used while carrier is on
//   msf_carrier_pulse out  1      1-clk strobe per carrier period
//   one_sec_marker    out  1      with the strobe that starts each second
//   minute_marker     out  1      with the strobe that starts second 0
//   amplitude         out  NBITS  envelope (MSB always 0) or 0 when keyed off
//   carrier_on        out  1      current key state
//   second_index      out  6      current second 0..59
//   underrun          out  1      minute began with an empty shadow register
// ============================================================================
module msf_keyer #(
  parameter int NBITS            = 16,
  parameter int CLKS_PER_CARRIER = 2083,
  parameter int CYCLES_PER_TENTH = 6000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [59:0]      frame_a,
  input  logic [59:0]      frame_b,
  input  logic             frame_valid,
  output logic             frame_ready,
  input  logic [NBITS-1:0] amplitude_level,
  output logic             msf_carrier_pulse,
  output logic             one_sec_marker,
  output logic             minute_marker,
  output logic [NBITS-1:0] amplitude,
  output logic             carrier_on,
  output logic [5:0]       second_index,
  output logic             underrun
);

  localparam int PW = (CLKS_PER_CARRIER > 1) ? $clog2(CLKS_PER_CARRIER) : 1;
  localparam int CW = (CYCLES_PER_TENTH > 1) ? $clog2(CYCLES_PER_TENTH) : 1;
  localparam logic [PW-1:0]    C_P_LAST   = PW'(CLKS_PER_CARRIER - 1);
  localparam logic [CW-1:0]    C_C_LAST   = CW'(CYCLES_PER_TENTH - 1);
  // Clearing the MSB keeps the envelope non-negative when read as signed.
  localparam logic [NBITS-1:0] C_MAG_MASK = {1'b0, {(NBITS-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PW-1:0]    r_p;
  logic [CW-1:0]    r_c;
  logic [3:0]       r_t;
  logic [5:0]       r_s;
  logic             r_pulse;
  logic             r_one_sec;
  logic             r_minute;
  logic             r_carrier_on;
  logic [NBITS-1:0] r_amp;
  logic             r_underrun;
  logic [59:0]      r_act_a;
  logic [59:0]      r_act_b;
  logic [59:0]      r_sh_a;
  logic [59:0]      r_sh_b;
  logic             r_sh_full;

  logic             w_period_end;
  logic             w_new_period;
  logic [CW-1:0]    w_c_nxt;
  logic [3:0]       w_t_nxt;
  logic [5:0]       w_s_nxt;
  logic             w_carrier_nxt;
  logic             w_xfer;
  logic             w_load;

  // Key state for second s, tenth t of the minute described by frames a/b.
  function automatic logic f_key(input logic [5:0]  s,
                                 input logic [3:0]  t,
                                 input logic [59:0] a,
                                 input logic [59:0] b);
    logic on;
    on = 1'b1;
    if (t == 4'd0)                    on = 1'b0;
    if ((s == 6'd0) && (t <= 4'd4))   on = 1'b0;
    if ((t == 4'd1) && a[s])          on = 1'b0;
    if ((t == 4'd2) && b[s])          on = 1'b0;
    return on;
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, position of the period about to start and its key state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_period_end  = 1'b0;
    w_new_period  = 1'b0;
    w_c_nxt       = r_c;
    w_t_nxt       = r_t;
    w_s_nxt       = r_s;
    w_carrier_nxt = r_carrier_on;
    if (!enable) begin
      w_state_nxt   = ST_IDLE;
      w_carrier_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_SYNC;
          w_carrier_nxt = 1'b1;
        end
        ST_SYNC: begin
          w_period_end  = (r_p == C_P_LAST);
          w_carrier_nxt = 1'b1;
          // The first RUN period is minute start; its shadow gets consumed
          // by the transfer on the following clk.
          if (w_period_end && r_sh_full) begin
            w_state_nxt   = ST_RUN;
            w_new_period  = 1'b1;
            w_c_nxt       = '0;
            w_t_nxt       = '0;
            w_s_nxt       = '0;
            w_carrier_nxt = f_key(6'd0, 4'd0, r_act_a, r_act_b);
          end
        end
        ST_RUN: begin
          w_period_end = (r_p == C_P_LAST);
          if (w_period_end) begin
            w_new_period = 1'b1;
            if (r_c == C_C_LAST) begin
              w_c_nxt = '0;
              if (r_t == 4'd9) begin
                w_t_nxt = '0;
                w_s_nxt = (r_s == 6'd59) ? 6'd0 : r_s + 6'd1;
              end else begin
                w_t_nxt = r_t + 4'd1;
              end
            end else begin
              w_c_nxt = r_c + CW'(1);
            end
            w_carrier_nxt = f_key(w_s_nxt, w_t_nxt, r_act_a, r_act_b);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // The frame swap happens in the clk that presents the minute marker.
  assign w_xfer = enable && (r_state == ST_RUN) && r_minute;
  // The transfer frees the shadow slot on the same edge, so a frame offered
  // during the transfer clk is taken even though frame_ready reads 0.
  assign w_load = frame_valid && (!r_sh_full || w_xfer);

  // --------------------------------------------------------------------------
  // Datapath: prescaler, position counters, outputs and frame registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_p          <= '0;
      r_c          <= '0;
      r_t          <= '0;
      r_s          <= '0;
      r_pulse      <= 1'b0;
      r_one_sec    <= 1'b0;
      r_minute     <= 1'b0;
      r_carrier_on <= 1'b0;
      r_amp        <= '0;
      r_underrun   <= 1'b0;
      r_act_a      <= '0;
      r_act_b      <= '0;
      r_sh_a       <= '0;
      r_sh_b       <= '0;
      r_sh_full    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_p <= '0;
      end else begin
        r_p <= w_period_end ? '0 : r_p + PW'(1);
      end
      r_pulse      <= w_period_end;
      r_one_sec    <= w_new_period && (w_t_nxt == 4'd0) && (w_c_nxt == '0);
      r_minute     <= w_new_period && (w_t_nxt == 4'd0) && (w_c_nxt == '0)
                      && (w_s_nxt == 6'd0);
      r_c          <= w_c_nxt;
      r_t          <= w_t_nxt;
      r_s          <= w_s_nxt;
      r_carrier_on <= w_carrier_nxt;
      r_amp        <= w_carrier_nxt ? (amplitude_level & C_MAG_MASK) : '0;
      r_underrun   <= w_xfer && !r_sh_full;

      if (w_xfer) begin
        r_act_a <= r_sh_full ? r_sh_a : '0;
        r_act_b <= r_sh_full ? r_sh_b : '0;
      end

      if (w_load) begin
        r_sh_a    <= frame_a;
        r_sh_b    <= frame_b;
        r_sh_full <= 1'b1;
      end else if (w_xfer) begin
        r_sh_full <= 1'b0;
      end
    end
  end

  assign frame_ready       = ~r_sh_full;
  assign msf_carrier_pulse = r_pulse;
  assign one_sec_marker    = r_one_sec;
  assign minute_marker     = r_minute;
  assign amplitude         = r_amp;
  assign carrier_on        = r_carrier_on;
  assign second_index      = r_s;
  assign underrun          = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_msf_keyer.sv
`default_nettype none
// ============================================================================
// Module   : tb_msf_keyer
// Purpose  : Scoreboard bench for msf_keyer with a short carrier period
//            (4 clk) and short tenth (3 periods): one second = 120 clk.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msf_keyer;

  localparam int NB  = 16;
  localparam int CPC = 4;
  localparam int CPT = 3;
  localparam int PULSES_PER_SEC = CPT * 10;
  localparam int PULSES_PER_MIN = PULSES_PER_SEC * 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [59:0]   frame_a = '0;
  logic [59:0]   frame_b = '0;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [NB-1:0] amplitude_level = 16'd1000;
  logic          msf_carrier_pulse;
  logic          one_sec_marker;
  logic          minute_marker;
  logic [NB-1:0] amplitude;
  logic          carrier_on;
  logic [5:0]    second_index;
  logic          underrun;

  msf_keyer #(
    .NBITS            (NB),
    .CLKS_PER_CARRIER (CPC),
    .CYCLES_PER_TENTH (CPT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .frame_a           (frame_a),
    .frame_b           (frame_b),
    .frame_valid       (frame_valid),
    .frame_ready       (frame_ready),
    .amplitude_level   (amplitude_level),
    .msf_carrier_pulse (msf_carrier_pulse),
    .one_sec_marker    (one_sec_marker),
    .minute_marker     (minute_marker),
    .amplitude         (amplitude),
    .carrier_on        (carrier_on),
    .second_index      (second_index),
    .underrun          (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mm;
    logic          os;
    logic          co;
    logic [5:0]    sec;
    logic [NB-1:0] amp;
  } rec_t;

  rec_t q[$];

  int tests = 0;
  int fails = 0;

  // --------------------------------------------------------------------------
  // Reference model: time measured in clocks since enable and in carrier
  // periods since the first minute start; position derived arithmetically.
  // --------------------------------------------------------------------------
  int          m_k = -1;
  int          m_n = -1;
  bit          m_sh_full = 0;
  logic [59:0] m_sh_a = '0, m_sh_b = '0, m_act_a = '0, m_act_b = '0;
  bit          m_xfer_pend = 0;
  bit          m_exp_underrun = 0;
  bit          m_acc = 0;
  int          m_pushed = 0;

  function automatic bit key(int s, int t, logic [59:0] a, logic [59:0] b);
    if (t == 0) return 1'b0;
    if (s == 0 && t <= 4) return 1'b0;
    if (t == 1 && a[s]) return 1'b0;
    if (t == 2 && b[s]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : p_model
    bit   old_full, xfer, acc;
    int   s, t, c;
    rec_t r;
    m_acc = 0;
    m_exp_underrun = 0;
    if (rst || !enable) begin
      m_k = -1; m_n = -1; m_sh_full = 0; m_xfer_pend = 0;
      m_sh_a = '0; m_sh_b = '0; m_act_a = '0; m_act_b = '0;
    end else begin
      old_full = m_sh_full;
      xfer = m_xfer_pend;
      m_xfer_pend = 0;
      acc = frame_valid && (!old_full || xfer);
      if (xfer) begin
        if (old_full) begin
          m_act_a = m_sh_a; m_act_b = m_sh_b;
        end else begin
          m_act_a = '0; m_act_b = '0; m_exp_underrun = 1;
        end
        m_sh_full = 0;
      end
      if (acc) begin
        m_sh_a = frame_a; m_sh_b = frame_b; m_sh_full = 1; m_acc = 1;
      end
      m_k++;
      if (m_k > 0 && m_k % CPC == 0) begin
        if (m_n >= 0) m_n++;
        else if (old_full) m_n = 0;
        if (m_n < 0) begin
          r = '{mm: 1'b0, os: 1'b0, co: 1'b1, sec: 6'd0,
                amp: amplitude_level & 16'h7FFF};
        end else begin
          s = (m_n / PULSES_PER_SEC) % 60;
          t = (m_n / CPT) % 10;
          c = m_n % CPT;
          r.os  = (t == 0 && c == 0);
          r.mm  = r.os && (s == 0);
          r.co  = key(s, t, m_act_a, m_act_b);
          r.sec = 6'(s);
          r.amp = r.co ? (amplitude_level & 16'h7FFF) : 16'd0;
          if (m_n % PULSES_PER_MIN == 0) m_xfer_pend = 1;
        end
        q.push_back(r);
        m_pushed++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  int dut_pulses = 0;
  int dut_underruns = 0;

  always @(negedge clk) begin : p_mon
    rec_t exp_r, act_r;
    act_r = {minute_marker, one_sec_marker, carrier_on, second_index, amplitude};
    if (msf_carrier_pulse === 1'b1) begin
      dut_pulses++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse t=%0t got mm=%b os=%b co=%b sec=%0d amp=%0d, required no pulse",
                 $time, act_r.mm, act_r.os, act_r.co, act_r.sec, act_r.amp);
      end else begin
        exp_r = q.pop_front();
        if (act_r !== exp_r) begin
          fails++;
          $display("FAIL pulse_fields t=%0t got mm=%b os=%b co=%b sec=%0d amp=%0d, required mm=%b os=%b co=%b sec=%0d amp=%0d",
                   $time, act_r.mm, act_r.os, act_r.co, act_r.sec, act_r.amp,
                   exp_r.mm, exp_r.os, exp_r.co, exp_r.sec, exp_r.amp);
        end
      end
    end else begin
      if (q.size() != 0) begin
        tests++; fails++;
        $display("FAIL missing_pulse t=%0t got pulse=%b, required pulse=1", $time, msf_carrier_pulse);
        q.delete();
      end
      if (one_sec_marker !== 1'b0 || minute_marker !== 1'b0) begin
        tests++; fails++;
        $display("FAIL stray_marker t=%0t got os=%b mm=%b, required 0 0", $time, one_sec_marker, minute_marker);
      end
    end

    tests++;
    if (frame_ready !== !m_sh_full) begin
      fails++;
      $display("FAIL frame_ready t=%0t got %b, required %b", $time, frame_ready, !m_sh_full);
    end

    if (underrun === 1'b1) dut_underruns++;
    if (underrun !== 1'b0 || m_exp_underrun) begin
      tests++;
      if (underrun !== m_exp_underrun) begin
        fails++;
        $display("FAIL underrun t=%0t got %b, required %b", $time, underrun, m_exp_underrun);
      end
    end

    if (m_k < 0) begin
      tests++;
      if ({msf_carrier_pulse, one_sec_marker, minute_marker, carrier_on, underrun} !== 5'b0 ||
          amplitude !== '0 || second_index !== '0 || frame_ready !== 1'b1) begin
        fails++;
        $display("FAIL idle_outputs t=%0t got pulse=%b os=%b mm=%b co=%b ur=%b amp=%0d sec=%0d rdy=%b, required all 0 rdy=1",
                 $time, msf_carrier_pulse, one_sec_marker, minute_marker, carrier_on, underrun,
                 amplitude, second_index, frame_ready);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  bit rnd_level = 0;

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_level && $urandom_range(0, 15) == 0) amplitude_level = 16'($urandom);
    end
  endtask

  task automatic send_frame(logic [59:0] a, logic [59:0] b, int budget);
    bit done;
    done = 0;
    frame_a = a;
    frame_b = b;
    frame_valid = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      step(1);
      if (m_acc) done = 1;
    end
    frame_valid = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL frame_accept_timeout t=%0t got no acceptance, required acceptance within %0d clk", $time, budget);
    end
  endtask

  task automatic wait_n(int target, int budget);
    int i;
    i = 0;
    while (m_n < target && i < budget) begin
      step(1);
      i++;
    end
    if (m_n < target) begin
      tests++; fails++;
      $display("FAIL wait_timeout t=%0t got period %0d, required %0d", $time, m_n, target);
    end
  endtask

  function automatic logic [59:0] rnd60();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[59:0];
  endfunction

  initial begin : p_stim
    logic [59:0] a, b;
    step(5);
    rst = 1'b0;
    step(100);

    // SYNC without a frame: pulses with carrier on, no markers.
    enable = 1'b1;
    step(41);

    // First frame: A[1]=1, B[2]=1, seconds 1..3 otherwise clear.
    a = rnd60(); b = rnd60();
    a[3:1] = 3'b001;
    b[3:1] = 3'b010;
    send_frame(a, b, 10);

    // Fixed level through seconds 0..3, then random levels.
    wait_n(4 * PULSES_PER_SEC, 2000);
    rnd_level = 1;

    // No frame for minute 1: underrun at the wrap, markers only.
    wait_n(PULSES_PER_MIN + 5 * PULSES_PER_SEC, PULSES_PER_MIN * CPC + 1000);
    send_frame(rnd60(), rnd60(), 10);

    // Minute 2 runs the second frame; fill shadow, then hold a fourth frame
    // valid so it lands on the minute-3 transfer clk.
    wait_n(2 * PULSES_PER_MIN + 2 * PULSES_PER_SEC, PULSES_PER_MIN * CPC + 1000);
    send_frame(rnd60(), rnd60(), 10);
    send_frame(rnd60(), rnd60(), PULSES_PER_MIN * CPC + 100);

    // Drop enable at s=30, t=5 of minute 3.
    wait_n(3 * PULSES_PER_MIN + 30 * PULSES_PER_SEC + 5 * CPT, PULSES_PER_MIN * CPC);
    enable = 1'b0;
    step(20);

    // Re-enable: SYNC again, markers only once a frame is supplied.
    enable = 1'b1;
    step(30);
    send_frame(rnd60(), rnd60(), 10);
    wait_n(3 * PULSES_PER_SEC + 5, 2000);
    step(3);
    enable = 1'b0;
    step(3);

    tests++;
    if (dut_underruns != 1) begin
      fails++;
      $display("FAIL underrun_count got %0d, required 1", dut_underruns);
    end
    tests++;
    if (dut_pulses != m_pushed) begin
      fails++;
      $display("FAIL pulse_count got %0d, required %0d", dut_pulses, m_pushed);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
